moore_seq_detector_param: RTL and testbench

MOORE_SEQ_DETECTOR_PARAM -- requirements
Module: moore_seq_detector_param

---
 rtl/seq_det_pkg.sv | 16 +
 rtl/sat_counter.sv | 41 ++++
 rtl/moore_seq_detector_param.sv | 93 +++++++++
 tb/tb_moore_seq_detector_param.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parameterised Moore sequence detector.
//   DEFAULT_PATTERN : reset value of the pattern register (MSB = oldest bit)
//   OVERLAP_ON/OFF  : detection-mode selector values for the OVERLAP parameter
//   fill_width()    : bits needed to hold a fill count of 0..pat_len
package seq_det_pkg;

  localparam logic [4:0] DEFAULT_PATTERN = 5'b11011;

  localparam int OVERLAP_OFF = 0;
  localparam int OVERLAP_ON  = 1;

  function automatic int fill_width(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used as the match counter.
//   clk, rst : clock and asynchronous active-high reset
//   inc      : count up by one (ignored once all-ones is reached)
//   clr      : synchronous clear, takes priority over inc
//   cnt      : current count
//   sat      : high while cnt is all-ones
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign sat = &cnt_q;
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/moore_seq_detector_param.sv
// Parameterised serial pattern detector with a registered (Moore) match flag.
//   clk, rst  : clock and asynchronous active-high reset
//   in_valid  : in carries a serial bit this cycle
//   in        : serial data bit
//   pat_load  : load pat_in into the pattern register and restart detection
//   pat_in    : new pattern, MSB oldest
//   cnt_clr   : synchronous clear of match_cnt
//   out       : one-cycle match pulse, registered
//   match_cnt : saturating number of matches
//   cnt_sat   : match_cnt is all-ones
module moore_seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                   PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0]   PATTERN = PAT_LEN'(DEFAULT_PATTERN),
  parameter int                   OVERLAP = OVERLAP_ON,
  parameter int                   CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               cnt_clr,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  localparam int             FW        = fill_width(PAT_LEN);
  localparam logic [FW-1:0]  FILL_FULL = FW'(PAT_LEN);

  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               out_q, out_d;

  logic [PAT_LEN-1:0] hist_shift;
  logic [FW-1:0]      fill_inc;
  logic               match;

  always_comb begin
    hist_shift = {hist_q[PAT_LEN-2:0], in};
    fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    // Match is judged on the post-update history; a pattern load discards
    // the bit offered in the same cycle.
    match      = in_valid && !pat_load && (fill_inc == FILL_FULL) &&
                 (hist_shift == pat_q);

    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    out_d  = match;

    if (pat_load) begin
      pat_d  = pat_in;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = hist_shift;
      // Non-overlapping mode restarts the fill so no bit of this match is reused.
      fill_d = (match && (OVERLAP == OVERLAP_OFF)) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= PATTERN;
      out_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .inc (match),
    .clr (cnt_clr),
    .cnt (match_cnt),
    .sat (cnt_sat)
  );

endmodule

// File: tb/tb_moore_seq_detector_param.sv
// Self-checking bench: three detector instances (overlapping, non-overlapping,
// 2-bit counter) share one stimulus stream and are compared every cycle
// against a bit-list model, with literal spot checks pinning the model.
module tb_moore_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_s = 1'b0;
  logic       pat_load = 1'b0;
  logic [4:0] pat_in = 5'b0;
  logic       cnt_clr = 1'b0;

  logic       out_a, out_n, out_c;
  logic [7:0] cnt_a, cnt_n;
  logic [1:0] cnt_c;
  logic       sat_a, sat_n, sat_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  moore_seq_detector_param dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_s), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .out(out_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
  );

  moore_seq_detector_param #(.OVERLAP(0)) dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_s), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .out(out_n), .match_cnt(cnt_n), .cnt_sat(sat_n)
  );

  moore_seq_detector_param #(.CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_s), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .out(out_c), .match_cnt(cnt_c), .cnt_sat(sat_c)
  );

  // Model: per instance, the accepted bits since the last restart (newest in
  // bit 0) and how many there are; a match is "at least 5 bits seen and the
  // last 5 equal the pattern".
  int       ovl[3]  = '{1, 0, 1};
  int       cmax[3] = '{255, 255, 3};
  bit [15:0] m_bits[3] = '{16'd0, 16'd0, 16'd0};
  int       m_n[3]   = '{0, 0, 0};
  bit [4:0] m_pat[3] = '{5'b11011, 5'b11011, 5'b11011};
  bit       m_out[3] = '{1'b0, 1'b0, 1'b0};
  int       m_cnt[3] = '{0, 0, 0};

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      bit m;
      m = 1'b0;
      if (rst) begin
        m_bits[k] = '0;
        m_n[k]    = 0;
        m_pat[k]  = 5'b11011;
        m_out[k]  = 1'b0;
        m_cnt[k]  = 0;
      end else begin
        if (pat_load) begin
          m_pat[k] = pat_in;
          m_n[k]   = 0;
        end else if (in_valid) begin
          m_bits[k] = {m_bits[k][14:0], in_s};
          m_n[k]    = m_n[k] + 1;
          if (m_n[k] >= 5 && m_bits[k][4:0] == m_pat[k]) begin
            m = 1'b1;
            if (ovl[k] == 0) m_n[k] = 0;
          end
        end
        m_out[k] = m;
        if (cnt_clr) m_cnt[k] = 0;
        else if (m && m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
      end
    end
  end

  task automatic cmp(input string nm, input int k, input logic o, input int c, input logic s);
    checks++;
    if (o !== m_out[k] || c != m_cnt[k] || s !== (m_cnt[k] == cmax[k])) begin
      failures++;
      $display("FAIL %s t=%0t: got out=%0b cnt=%0d sat=%0b, want out=%0b cnt=%0d sat=%0b",
               nm, $time, o, c, s, m_out[k], m_cnt[k], (m_cnt[k] == cmax[k]));
    end
  endtask

  always @(negedge clk) begin
    cmp("model_ovl", 0, out_a, int'(cnt_a), sat_a);
    cmp("model_novl", 1, out_n, int'(cnt_n), sat_n);
    cmp("model_cw2", 2, out_c, int'(cnt_c), sat_c);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t: got %0d, want %0d", nm, $time, act, exp);
    end
  endtask

  // Present one cycle of serial input, then return at the following negedge.
  task automatic step(input logic v, input logic b);
    in_valid = v;
    in_s     = b;
    @(negedge clk);
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
    in_valid = 1'b0;
  endtask

  int s1[8]  = '{1, 1, 0, 1, 1, 0, 1, 1};
  int s2[14] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
  int s3[5]  = '{1, 0, 1, 0, 1};

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out", int'(out_a | out_n | out_c), 0);
    chk("rst_cnt", int'(cnt_a) + int'(cnt_n) + int'(cnt_c), 0);
    chk("rst_sat", int'(sat_c), 0);
    rst = 1'b0;
    @(negedge clk);

    // Overlapping vs non-overlapping on the same stream.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, s1[i][0]);
      if (i == 4) begin
        chk("ovl_bit5", int'(out_a), 1);
        chk("novl_bit5", int'(out_n), 1);
      end
      if (i == 7) begin
        chk("ovl_bit8", int'(out_a), 1);
        chk("novl_bit8", int'(out_n), 0);
      end
    end
    step(1'b0, 1'b0);
    chk("ovl_cnt", int'(cnt_a), 2);
    chk("novl_cnt", int'(cnt_n), 1);
    chk("pulse_width", int'(out_a), 0);

    // Gap in in_valid must not disturb the partial pattern.
    pat_load = 1'b1; pat_in = 5'b11011; cnt_clr = 1'b1;
    step(1'b0, 1'b0);
    chk("clr_cnt", int'(cnt_a), 0);
    step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      chk("gap_out", int'(out_a), 0);
    end
    step(1'b1, 1'b1);
    chk("gap_early", int'(out_a), 0);
    step(1'b1, 1'b1);
    chk("gap_match", int'(out_a), 1);
    step(1'b0, 1'b0);
    chk("gap_cnt", int'(cnt_a), 1);

    // pat_load wins over a coincident in_valid bit.
    pat_load = 1'b1; pat_in = 5'b10101;
    step(1'b1, 1'b1);
    chk("load_out", int'(out_a), 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, s3[i][0]);
      chk("load_stream", int'(out_a), (i == 4) ? 1 : 0);
    end
    step(1'b0, 1'b0);
    chk("load_cnt", int'(cnt_a), 2);

    // Saturation of a 2-bit counter, then clear racing a match.
    pat_load = 1'b1; pat_in = 5'b11011; cnt_clr = 1'b1;
    step(1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b1, s2[i][0]);
    chk("sat_cnt", int'(cnt_c), 3);
    chk("sat_flag", int'(sat_c), 1);
    chk("wide_cnt", int'(cnt_a), 4);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    cnt_clr = 1'b1;
    step(1'b1, 1'b1);
    chk("clr_win_out", int'(out_a), 1);
    chk("clr_win_cnt", int'(cnt_a) + int'(cnt_c), 0);
    chk("clr_win_sat", int'(sat_c), 0);

    // Reset mid-pattern discards the partial match.
    step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
    // Bits so far in this window: 1,1,1,0,1 after the previous match.
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_out", int'(out_a | out_n | out_c), 0);
    chk("rst_mid_cnt", int'(cnt_a) + int'(cnt_n) + int'(cnt_c), 0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b1);
    chk("rst_nopulse", int'(out_a | out_n), 0);
    step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
    chk("rst_restart_early", int'(out_a), 0);
    step(1'b1, 1'b1);
    chk("rst_restart_match", int'(out_a), 1);
    step(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
